// File: rtl/bus_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// bus_cycle_ctrl
//
// Multi-cycle sequencer for the external instruction/data bus. Each
// instruction walks FETCH -> EXEC -> (MEM) -> WB. The PC and register file
// are only strobed in WB, after the active-low bus acknowledges have arrived,
// so memories with wait states stall the core instead of corrupting it.
//
// Parameters
//   TIMEOUT_CYCLES : wait cycles allowed in FETCH or MEM before the abort
//                    (2..255, only used when BUS_TIMEOUT_EN is defined)
//   TO_W           : width of the timeout counter, must hold TIMEOUT_CYCLES
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   ACKI_n     in   instruction bus acknowledge (active-low, IDT valid)
//   ACKD_n     in   data bus acknowledge (active-low, DDT read data valid)
//   mem_rd     in   decoded instruction is a load
//   mem_wr     in   decoded instruction is a store
//   reg_write  in   decoded instruction writes rd
//   ifetch     out  instruction request, IAD valid
//   ir_load    out  latch IDT into the instruction register (combinational)
//   dreq       out  data request (MREQ)
//   dwrite     out  data write (WRITE)
//   ddt_oe     out  DDT tristate output enable
//   rd_load    out  latch DDT into the load-data register (combinational)
//   rf_we      out  register file write strobe
//   pc_en      out  PC update strobe
//   ill_op     out  one-cycle pulse in WB after an EXEC with load+store set
//   bus_err    out  sticky bus-timeout flag
//   state      out  current state (debug)
//
// Build option
//   BUS_TIMEOUT_EN : when defined, a wait longer than TIMEOUT_CYCLES in FETCH
//                    or MEM parks the sequencer in HALT with bus_err set.
//                    When undefined the block waits forever and bus_err is 0.
// ---------------------------------------------------------------------------
module bus_cycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ACKI_n,
  input  logic       ACKD_n,
  input  logic       mem_rd,
  input  logic       mem_wr,
  input  logic       reg_write,
  output logic       ifetch,
  output logic       ir_load,
  output logic       dreq,
  output logic       dwrite,
  output logic       ddt_oe,
  output logic       rd_load,
  output logic       rf_we,
  output logic       pc_en,
  output logic       ill_op,
  output logic       bus_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  // Elaboration-time guard on the timeout configuration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 ||
      TIMEOUT_CYCLES > (2 ** TO_W) - 1) begin : g_bad_cfg
    $error("bus_cycle_ctrl: TIMEOUT_CYCLES must be 2..255 and fit in TO_W bits");
  end

  state_e state_q, state_d;

  // run_q is low for exactly one cycle after reset: it forces a clean entry
  // into FETCH so the first cycle after reset always shows ifetch=1, no
  // matter what the ack pins were doing while reset was held.
  logic run_q;

  // Decoder controls captured in EXEC and held for MEM/WB.
  logic rd_lat_q, rd_lat_d;
  logic wr_lat_q, wr_lat_d;
  logic we_lat_q, we_lat_d;
  logic ill_d;

  // Registered strobes, decoded from the next state so they line up with
  // the state register.
  logic ifetch_q;
  logic dreq_q;
  logic dwrite_q;
  logic rf_we_q;
  logic pc_en_q;
  logic ill_op_q;

  logic timeout_hit;

`ifdef BUS_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            bus_err_q;

  // Last permitted wait cycle; an ack in this cycle still wins because the
  // ack checks come first in the next-state logic.
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state and latch logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rd_lat_d = rd_lat_q;
    wr_lat_d = wr_lat_q;
    we_lat_d = we_lat_q;
    ill_d    = 1'b0;

    if (!run_q) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!ACKI_n) begin
            state_d = ST_EXEC;
          end else if (timeout_hit) begin
            state_d = ST_HALT;
          end
        end

        ST_EXEC: begin
          rd_lat_d = mem_rd;
          wr_lat_d = mem_wr;
          // An illegal load+store must never write the register file.
          we_lat_d = reg_write & ~(mem_rd & mem_wr);
          if (mem_rd && mem_wr) begin
            ill_d   = 1'b1;
            state_d = ST_WB;
          end else if (mem_rd || mem_wr) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end

        ST_MEM: begin
          if (!ACKD_n) begin
            state_d = ST_WB;
          end else if (timeout_hit) begin
            state_d = ST_HALT;
          end
        end

        ST_WB: begin
          state_d = ST_FETCH;
        end

        ST_HALT: begin
          state_d = ST_HALT;
        end

        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Counter restarts on every state change (covers entry to FETCH and MEM)
  // and counts only while parked waiting for an ack.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!run_q || state_d != state_q) begin
      to_cnt_d = '0;
    end else if (state_q == ST_FETCH || state_q == ST_MEM) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      run_q    <= 1'b0;
      rd_lat_q <= 1'b0;
      wr_lat_q <= 1'b0;
      we_lat_q <= 1'b0;
      ifetch_q <= 1'b0;
      dreq_q   <= 1'b0;
      dwrite_q <= 1'b0;
      rf_we_q  <= 1'b0;
      pc_en_q  <= 1'b0;
      ill_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      rd_lat_q <= rd_lat_d;
      wr_lat_q <= wr_lat_d;
      we_lat_q <= we_lat_d;
      ifetch_q <= (state_d == ST_FETCH);
      dreq_q   <= (state_d == ST_MEM);
      dwrite_q <= (state_d == ST_MEM) && wr_lat_d;
      rf_we_q  <= (state_d == ST_WB) && we_lat_d;
      pc_en_q  <= (state_d == ST_WB);
      ill_op_q <= ill_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      // HALT is only left through reset, so this is sticky.
      bus_err_q <= (state_d == ST_HALT);
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ifetch  = ifetch_q;
  assign dreq    = dreq_q;
  assign dwrite  = dwrite_q;
  assign ddt_oe  = dwrite_q;
  assign rf_we   = rf_we_q;
  assign pc_en   = pc_en_q;
  assign ill_op  = ill_op_q;
  assign state   = state_q;

  // Acks only matter in their own wait state: ifetch_q / dreq_q are high
  // exactly in FETCH / MEM, and both are low throughout reset.
  assign ir_load = ifetch_q & ~ACKI_n;
  assign rd_load = dreq_q & rd_lat_q & ~ACKD_n;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_cycle_ctrl
//
// Cycle-table bench for bus_cycle_ctrl. Each scenario task builds a table of
// per-cycle inputs and the outputs expected in that cycle; the expected
// vector is pushed to a scoreboard queue when the inputs are applied and
// popped and compared once the outputs have settled.
//
// Expected vector layout: {state[2:0], ifetch, ir_load, dreq, dwrite,
// ddt_oe, rd_load, rf_we, pc_en, ill_op, bus_err}.
// Stimulus bits layout:   {rst, ACKI_n, ACKD_n, mem_rd, mem_wr, reg_write}.
// ---------------------------------------------------------------------------
module tb_bus_cycle_ctrl;

  localparam int TIMEOUT_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ACKI_n = 1'b1;
  logic       ACKD_n = 1'b1;
  logic       mem_rd = 1'b0;
  logic       mem_wr = 1'b0;
  logic       reg_write = 1'b0;
  logic       ifetch, ir_load, dreq, dwrite, ddt_oe, rd_load;
  logic       rf_we, pc_en, ill_op, bus_err;
  logic [2:0] state;

  always #5 clk = ~clk;

  bus_cycle_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ACKI_n   (ACKI_n),
    .ACKD_n   (ACKD_n),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .reg_write(reg_write),
    .ifetch   (ifetch),
    .ir_load  (ir_load),
    .dreq     (dreq),
    .dwrite   (dwrite),
    .ddt_oe   (ddt_oe),
    .rd_load  (rd_load),
    .rf_we    (rf_we),
    .pc_en    (pc_en),
    .ill_op   (ill_op),
    .bus_err  (bus_err),
    .state    (state)
  );

  // Output flag masks
  localparam logic [9:0] F_NONE = 10'b0000000000;
  localparam logic [9:0] F_IF   = 10'b1000000000;
  localparam logic [9:0] F_IRLD = 10'b0100000000;
  localparam logic [9:0] F_DREQ = 10'b0010000000;
  localparam logic [9:0] F_DWR  = 10'b0001000000;
  localparam logic [9:0] F_OE   = 10'b0000100000;
  localparam logic [9:0] F_RDLD = 10'b0000010000;
  localparam logic [9:0] F_RFWE = 10'b0000001000;
  localparam logic [9:0] F_PCEN = 10'b0000000100;
  localparam logic [9:0] F_ILL  = 10'b0000000010;
  localparam logic [9:0] F_BERR = 10'b0000000001;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  typedef struct packed {
    logic [5:0]  in;
    logic [12:0] exp;
  } stim_t;

  stim_t       tbl[$];
  logic [12:0] sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [12:0] got;
  logic [12:0] want;

  function automatic stim_t s(input logic [5:0] in, input logic [2:0] st,
                              input logic [9:0] f);
    stim_t t;
    t.in  = in;
    t.exp = {st, f};
    return t;
  endfunction

  function automatic logic [12:0] observed();
    return {state, ifetch, ir_load, dreq, dwrite, ddt_oe, rd_load,
            rf_we, pc_en, ill_op, bus_err};
  endfunction

  // Drive one cycle of inputs and queue what the DUT should show this cycle.
  task automatic apply(input stim_t t);
    {rst, ACKI_n, ACKD_n, mem_rd, mem_wr, reg_write} = t.in;
    sb.push_back(t.exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    tbl.delete();
    // Acks held low during reset must not leak through ir_load/rd_load.
    tbl.push_back(s(6'b100001, S_FETCH, F_NONE));
    tbl.push_back(s(6'b100001, S_FETCH, F_NONE));
    tbl.push_back(s(6'b010000, S_FETCH, F_NONE));
    tbl.push_back(s(6'b010000, S_FETCH, F_IF));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_reset[%0d]: got=%b required=%b", i, got, want);
      end
      next_cycle();
    end
    $display("test_reset: %0d cycles", tbl.size());
  endtask

  // -------------------------------------------------------------------------
  task automatic test_alu();
    tbl.delete();
    for (int n = 0; n < 2; n++) begin
      tbl.push_back(s(6'b000001, S_FETCH, F_IF | F_IRLD));
      tbl.push_back(s(6'b000001, S_EXEC,  F_NONE));
      tbl.push_back(s(6'b000001, S_WB,    F_RFWE | F_PCEN));
    end
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_alu[%0d]: got=%b required=%b", i, got, want);
      end
      next_cycle();
    end
    $display("test_alu: %0d cycles", tbl.size());
  endtask

  // -------------------------------------------------------------------------
  task automatic test_load_wait();
    tbl.delete();
    tbl.push_back(s(6'b000000, S_FETCH, F_IF | F_IRLD));
    tbl.push_back(s(6'b001101, S_EXEC,  F_NONE));
    // Decoder inputs change during MEM; the latched load must hold.
    tbl.push_back(s(6'b001010, S_MEM,   F_DREQ));
    tbl.push_back(s(6'b001010, S_MEM,   F_DREQ));
    tbl.push_back(s(6'b001010, S_MEM,   F_DREQ));
    tbl.push_back(s(6'b000010, S_MEM,   F_DREQ | F_RDLD));
    tbl.push_back(s(6'b010000, S_WB,    F_RFWE | F_PCEN));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_load_wait[%0d]: got=%b required=%b", i, got, want);
      end
      next_cycle();
    end
    $display("test_load_wait: %0d cycles", tbl.size());
  endtask

  // -------------------------------------------------------------------------
  task automatic test_store();
    tbl.delete();
    tbl.push_back(s(6'b010000, S_FETCH, F_IF));
    tbl.push_back(s(6'b000000, S_FETCH, F_IF | F_IRLD));
    tbl.push_back(s(6'b001010, S_EXEC,  F_NONE));
    tbl.push_back(s(6'b000101, S_MEM,   F_DREQ | F_DWR | F_OE));
    tbl.push_back(s(6'b010000, S_WB,    F_PCEN));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_store[%0d]: got=%b required=%b", i, got, want);
      end
      next_cycle();
    end
    $display("test_store: %0d cycles", tbl.size());
  endtask

  // -------------------------------------------------------------------------
  task automatic test_illegal();
    tbl.delete();
    tbl.push_back(s(6'b000000, S_FETCH, F_IF | F_IRLD));
    tbl.push_back(s(6'b000111, S_EXEC,  F_NONE));
    tbl.push_back(s(6'b000000, S_WB,    F_PCEN | F_ILL));
    tbl.push_back(s(6'b010000, S_FETCH, F_IF));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_illegal[%0d]: got=%b required=%b", i, got, want);
      end
      next_cycle();
    end
    $display("test_illegal: %0d cycles", tbl.size());
  endtask

  // -------------------------------------------------------------------------
  task automatic test_rst_mid_mem();
    tbl.delete();
    tbl.push_back(s(6'b000000, S_FETCH, F_IF | F_IRLD));
    tbl.push_back(s(6'b001101, S_EXEC,  F_NONE));
    tbl.push_back(s(6'b001101, S_MEM,   F_DREQ));
    tbl.push_back(s(6'b101101, S_MEM,   F_DREQ));
    tbl.push_back(s(6'b000000, S_FETCH, F_NONE));
    tbl.push_back(s(6'b010000, S_FETCH, F_IF));
    tbl.push_back(s(6'b000000, S_FETCH, F_IF | F_IRLD));
    tbl.push_back(s(6'b000000, S_EXEC,  F_NONE));
    tbl.push_back(s(6'b010000, S_WB,    F_PCEN));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_rst_mid_mem[%0d]: got=%b required=%b", i, got, want);
      end
      next_cycle();
    end
    $display("test_rst_mid_mem: %0d cycles", tbl.size());
  endtask

  // -------------------------------------------------------------------------
  task automatic test_timeout();
    tbl.delete();
    tbl.push_back(s(6'b110000, S_FETCH, F_IF));
    tbl.push_back(s(6'b010000, S_FETCH, F_NONE));
`ifdef BUS_TIMEOUT_EN
    for (int n = 0; n < TIMEOUT_CYCLES; n++)
      tbl.push_back(s(6'b010000, S_FETCH, F_IF));
    tbl.push_back(s(6'b010000, S_HALT,  F_BERR));
    tbl.push_back(s(6'b000000, S_HALT,  F_BERR));
    tbl.push_back(s(6'b110000, S_HALT,  F_BERR));
    tbl.push_back(s(6'b010000, S_FETCH, F_NONE));
    // Ack arrives in the last permitted wait cycle and must win.
    for (int n = 0; n < TIMEOUT_CYCLES - 1; n++)
      tbl.push_back(s(6'b010000, S_FETCH, F_IF));
    tbl.push_back(s(6'b000000, S_FETCH, F_IF | F_IRLD));
`else
    // Without the timeout the sequencer simply keeps waiting.
    for (int n = 0; n < 40; n++)
      tbl.push_back(s(6'b010000, S_FETCH, F_IF));
    tbl.push_back(s(6'b000000, S_FETCH, F_IF | F_IRLD));
`endif
    tbl.push_back(s(6'b000000, S_EXEC,  F_NONE));
    tbl.push_back(s(6'b010000, S_WB,    F_PCEN));
    tbl.push_back(s(6'b010000, S_FETCH, F_IF));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      #1;
      got = observed(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL test_timeout[%0d]: got=%b required=%b", i, got, want);
      end
      next_cycle();
    end
    $display("test_timeout: %0d cycles", tbl.size());
  endtask

  // -------------------------------------------------------------------------
  initial begin
    next_cycle();
    test_reset();
    test_alu();
    test_load_wait();
    test_store();
    test_illegal();
    test_rst_mid_mem();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
